// File: rtl/mem_dump_reader_pkg.sv
// Shared types for the memory dump reader: FSM state encoding.
package mem_dump_reader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } dump_state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Walks an inclusive (wrapping) address range, issues one memory read per word and
// streams {address, data} over valid/ready. One read in flight at a time.
module mem_dump_reader
  import mem_dump_reader_pkg::*;
#(
  parameter int DEFAULT_WORD_W = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int READ_LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     first_addr,
  input  logic [ADDR_WIDTH-1:0]     last_addr,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [DEFAULT_WORD_W-1:0] mem_rdata,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [ADDR_WIDTH-1:0]     dout_addr,
  output logic [DEFAULT_WORD_W-1:0] dout_data,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

  dump_state_t               state_reg;
  dump_state_t               state_next;
  logic [ADDR_WIDTH-1:0]     cur_reg;
  logic [ADDR_WIDTH-1:0]     cur_next;
  logic [ADDR_WIDTH-1:0]     last_reg;
  logic [ADDR_WIDTH-1:0]     mem_addr_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [ADDR_WIDTH-1:0]     dout_addr_reg;
  logic [DEFAULT_WORD_W-1:0] dout_data_reg;
  logic                      handshake;
  logic                      last_word;
  logic                      capture;

  assign handshake = (state_reg == OUT) && dout_ready;
  assign last_word = (cur_reg == last_reg);
  // The final WAIT edge is the one on which mem_rdata carries the requested word.
  assign capture   = (state_reg == WAIT) && (cnt_reg == CNT_W'(1));

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = READ;
      READ: state_next = WAIT;
      WAIT: if (capture) state_next = OUT;
      OUT: begin
        if (handshake) state_next = last_word ? DONE : READ;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    mem_read   = (state_reg == READ);
    mem_write  = 1'b0;
    dout_valid = (state_reg == OUT);
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
  end

  assign mem_addr  = mem_addr_reg;
  assign dout_addr = dout_addr_reg;
  assign dout_data = dout_data_reg;

  // ---------------- address counter ----------------
  always_comb begin
    cur_next = cur_reg;
    if ((state_reg == IDLE) && start) begin
      cur_next = first_addr;
    end else if (handshake && !last_word) begin
      cur_next = cur_reg + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_reg      <= '0;
      last_reg     <= '0;
      mem_addr_reg <= '0;
    end else begin
      cur_reg <= cur_next;
      if ((state_reg == IDLE) && start) begin
        last_reg <= last_addr;
      end
      // Load the port address on entry to READ so it is valid during that cycle
      // and simply holds afterwards.
      if (state_next == READ) begin
        mem_addr_reg <= cur_next;
      end
    end
  end

  // ---------------- read latency counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_reg == READ) begin
      cnt_reg <= CNT_W'(READ_LATENCY);
    end else if (state_reg == WAIT) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // ---------------- output word register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_addr_reg <= '0;
      dout_data_reg <= '0;
    end else if (capture) begin
      dout_addr_reg <= cur_reg;
      dout_data_reg <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: a READ_LATENCY=1 instance for the stream tests and a
// READ_LATENCY=3 instance for latency/period, each with a behavioural memory.
module tb_mem_dump_reader;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          a_start, a_mem_read, a_mem_write, a_valid, a_ready, a_busy, a_done;
  logic [AW-1:0] a_first, a_last, a_mem_addr, a_addr;
  logic [DW-1:0] a_mem_rdata, a_data;
  logic          b_start, b_mem_read, b_mem_write, b_valid, b_ready, b_busy, b_done;
  logic [AW-1:0] b_first, b_last, b_mem_addr, b_addr;
  logic [DW-1:0] b_mem_rdata, b_data;

  mem_dump_reader #(.DEFAULT_WORD_W(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .first_addr(a_first), .last_addr(a_last),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_rdata(a_mem_rdata), .dout_valid(a_valid), .dout_ready(a_ready),
    .dout_addr(a_addr), .dout_data(a_data), .busy(a_busy), .done(a_done));

  mem_dump_reader #(.DEFAULT_WORD_W(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .first_addr(b_first), .last_addr(b_last),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_rdata(b_mem_rdata), .dout_valid(b_valid), .dout_ready(b_ready),
    .dout_addr(b_addr), .dout_data(b_data), .busy(b_busy), .done(b_done));

  // Memories: the read is sampled on an edge, data emerges LAT edges later.
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] pipe_a [LAT_A];
  logic [DW-1:0] pipe_b [LAT_B];

  always @(posedge clk) begin
    if (a_mem_read) pipe_a[0] <= mem_a[a_mem_addr];
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
  end
  always @(posedge clk) begin
    if (b_mem_read) pipe_b[0] <= mem_b[b_mem_addr];
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign a_mem_rdata = pipe_a[LAT_A-1];
  assign b_mem_rdata = pipe_b[LAT_B-1];

  function automatic logic [DW-1:0] ref_a(input int addr);
    return DW'(addr) ^ 8'hA5;
  endfunction
  function automatic logic [DW-1:0] ref_b(input int addr);
    return DW'(addr * 7 + 3);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    bit            rand_ready;
    bit            inject;
    int            exp_words;
  } vec_t;

  vec_t vecs [7];

  // Runs one dump on instance A and scores it against the address/data model.
  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                          input bit rand_ready, input bit inject, input int exp_words);
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] ea;
    bit stalled, fin, injected;
    int got, reads, dones;
    for (int k = 0; k < exp_words; k++) begin
      exp_addr.push_back(AW'((int'(f) + k) % DEPTH));
      exp_data.push_back(ref_a((int'(f) + k) % DEPTH));
    end
    stalled = 0; fin = 0; injected = 0; got = 0; reads = 0; dones = 0;
    hold_addr = '0; hold_data = '0;
    @(negedge clk);
    a_first = f; a_last = l; a_start = 1'b1;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (cyc == 0) check("busy_after_start", a_busy, 1);
      if (a_mem_write) check("mem_write_low", a_mem_write, 0);
      if (a_mem_read) reads++;
      if (stalled) begin
        check("stall_hold", {a_valid, a_addr, a_data}, {1'b1, hold_addr, hold_data});
        stalled = 0;
      end
      if (a_done) begin
        dones++;
        fin = 1;
      end else begin
        if (inject && !injected && got == 5) begin
          a_start = 1'b1; a_first = 5'd3; a_last = 5'd3; injected = 1;
        end
        a_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (a_valid && a_ready) begin
          if (exp_addr.size() == 0) begin
            check("extra_word", 1, 0);
          end else begin
            ea = exp_addr.pop_front();
            check("word_addr", a_addr, ea);
            check("word_data", a_data, exp_data.pop_front());
          end
          got++;
        end else if (a_valid) begin
          stalled = 1; hold_addr = a_addr; hold_data = a_data;
        end
      end
    end
    if (!fin) check("dump_timeout", 0, 1);
    check("word_count", got, exp_words);
    check("read_strobes", reads, exp_words);
    check("done_pulses", dones, 1);
    @(negedge clk);
    check("idle_after_done", {a_busy, a_done}, 2'b00);
    $display("dump first=%0d last=%0d words=%0d reads=%0d", f, l, got, reads);
  endtask

  initial begin
    int k, prev, words;
    bit seen;
    logic [AW-1:0] rf, rl;

    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = ref_a(i);
      mem_b[i] = ref_b(i);
    end
    vecs[0] = '{5'd0,  5'd31, 1'b0, 1'b0, 32};
    vecs[1] = '{5'd0,  5'd31, 1'b1, 1'b0, 32};
    vecs[2] = '{5'd30, 5'd1,  1'b1, 1'b0, 4};
    vecs[3] = '{5'd7,  5'd7,  1'b0, 1'b0, 1};
    vecs[4] = '{5'd0,  5'd31, 1'b1, 1'b1, 32};
    vecs[5] = '{5'd5,  5'd4,  1'b1, 1'b0, 32};
    vecs[6] = '{5'd31, 5'd0,  1'b0, 1'b0, 2};

    rst_n = 1'b0;
    a_start = 0; a_first = '0; a_last = '0; a_ready = 1'b1;
    b_start = 0; b_first = '0; b_last = '0; b_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs_a",
          {a_mem_read, a_mem_write, a_mem_addr, a_valid, a_addr, a_data, a_busy, a_done}, 0);
    check("reset_outputs_b",
          {b_mem_read, b_mem_write, b_mem_addr, b_valid, b_addr, b_data, b_busy, b_done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++)
      run_dump(vecs[v].first, vecs[v].last, vecs[v].rand_ready, vecs[v].inject, vecs[v].exp_words);

    for (int r = 0; r < 4; r++) begin
      rf = AW'($urandom_range(0, DEPTH - 1));
      rl = AW'($urandom_range(0, DEPTH - 1));
      run_dump(rf, rl, 1'b1, 1'b0, ((int'(rl) - int'(rf) + DEPTH) % DEPTH) + 1);
    end

    // Reset while a word is waiting in OUT: everything clears immediately.
    @(negedge clk);
    a_ready = 1'b0; a_first = 5'd0; a_last = 5'd31; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (a_valid) seen = 1;
    end
    check("reached_out_before_reset", seen, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             {a_mem_read, a_mem_write, a_mem_addr, a_valid, a_addr, a_data, a_busy, a_done}, 0);
    @(negedge clk);
    check("no_done_in_reset", {a_done, a_busy}, 2'b00);
    rst_n = 1'b1;
    $display("reset during OUT applied and released");
    run_dump(5'd10, 5'd13, 1'b0, 1'b0, 4);

    // Latency-3 instance: first valid on the (LAT+2)th edge counting the start
    // sample edge as the first, then one word every LAT+2 cycles.
    @(negedge clk);
    b_first = 5'd0; b_last = 5'd3; b_ready = 1'b1; b_start = 1'b1;
    k = 0; prev = 0; words = 0; seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      k++;
      if (b_done) seen = 1;
      else if (b_valid) begin
        if (words == 0) check("lat3_first_valid_edge", k, LAT_B + 2);
        else check("lat3_period", k - prev, LAT_B + 2);
        check("lat3_addr", b_addr, words);
        check("lat3_data", b_data, ref_b(words));
        $display("lat3 word addr=%0d data=%0h edge=%0d", b_addr, b_data, k);
        prev = k;
        words++;
      end
    end
    check("lat3_done_seen", seen, 1);
    check("lat3_word_count", words, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
